wave_seq_ctrl: RTL
==================

WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 Parameter NSEG, default 4, number of program segments (power of two).
REQ-002 Parameter DUR_W, default 8, width of the segment duration field.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  program-table write strobe.
REQ-006 wr_addr  input  log2(NSEG)  table entry to write.
REQ-007 wr_data  input  6+DUR_W  entry {mode[1:0], step[3:0], dur[DUR_W-1:0]}, mode in MSBs.
REQ-008 start  input  1  begin playback; level sampled, acted on only in IDLE.
REQ-009 stop  input  1  abort playback.
REQ-010 loop  input  1  restart at segment 0 after last segment.
REQ-011 op  output  8  waveform sample.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse at end of non-looped playback.
REQ-014 seg  output  log2(NSEG)  index of current segment.

Function
REQ-015 States: IDLE, LOAD, RUN, DONE; one transition per clock.
REQ-016 IDLE: start=1 and stop=0 -> LOAD with seg=0; otherwise stay.
REQ-017 LOAD: copy entry[seg] into working regs; clear 8-bit phase and wrap count; dur=0 -> skip segment (advance per REQ-020), else -> RUN.
REQ-018 RUN: phase <= phase + step, mod 256; step=0 is treated as 1.
REQ-019 Wrap = carry out of the 8-bit add; each wrap increments wrap count; segment completes on the clock edge where wrap count reaches dur.
REQ-020 Segment completion: seg<NSEG-1 -> seg+1, LOAD; seg=NSEG-1 with loop=1 -> seg=0, LOAD; seg=NSEG-1 with loop=0 -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; seg holds last value until next start.
REQ-022 stop=1 in LOAD, RUN or DONE -> IDLE next edge; done is not asserted; stop beats completion and start in the same cycle.
REQ-023 op is a combinational decode of working mode and phase register: 00 -> 0x00; 01 -> phase[7] ? 0xFF : 0x00; 10 -> phase[6] ? 0xFF : 0x00; 11 -> phase.
REQ-024 op = 0x00 in IDLE, LOAD and DONE.
REQ-025 Latency: start sampled at edge t -> LOAD after t; first RUN cycle (phase=0) after edge t+1.
REQ-026 Table writes are accepted in any state; a write to the running entry takes effect only at that entry's next LOAD.
REQ-027 start while busy is ignored; loop is sampled only at last-segment completion.

Reset
REQ-028 rst=0 forces immediately, without clock: state IDLE, seg=0, phase=0, wrap count=0, op=0x00, busy=0, done=0.
REQ-029 Reset loads every table entry with {mode=01, step=1, dur=1}.
REQ-030 Reset asserted mid-RUN aborts playback; no done pulse is produced.

Structure
REQ-031 Package wave_seq_pkg holds the state enum, mode encodings, entry field widths and positions, and default-entry constant.
REQ-032 Sub-module wave_phase_gen holds the phase accumulator, step-0 substitution and wrap (carry) flag; the controller instantiates it once.

Verification
REQ-033 Reset defaults, loop=0, pulse start: each segment is 1 LOAD + 256 RUN cycles, op 0x00 for 128 cycles then 0xFF for 128; done pulses once 1028 cycles after LOAD entry; busy then 0.
REQ-034 Entry0 {mode=10, step=4, dur=2}: op toggles every 16 RUN cycles; segment lasts 128 RUN cycles; seg becomes 1.
REQ-035 Entry0 {mode=11, step=3, dur=1}: op ramps 0,3,...,255, then wraps to 2 with carry; segment completes on that edge (86 RUN cycles).
REQ-036 stop mid-RUN -> IDLE next edge, op=0x00, busy=0, done never asserted; start and stop together in IDLE -> stays IDLE.
REQ-037 loop=1, entries 0,1,3 dur=0, entry2 dur=1: seg runs 0,1,2,3,0,... with only entry2 producing RUN cycles; rewrite entry2 mid-RUN takes effect next pass.
REQ-038 rst=0 asynchronously mid-RUN -> op=0x00 and busy=0 before next clock edge.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the waveform sequencer: state and mode encodings,
// program-entry field layout, and the reset-default entry.
package wave_seq_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned PH_W   = 8;
  localparam int unsigned OP_W   = 8;

  // Entry layout is {mode, step, dur}; dur sits at the LSBs and its width is per-instance.
  localparam int unsigned DUR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SQ_HI  = 2'b01,
    MODE_SQ_MID = 2'b10,
    MODE_RAMP   = 2'b11
  } mode_e;

  localparam logic [MODE_W-1:0] DEF_MODE = MODE_SQ_HI;
  localparam logic [STEP_W-1:0] DEF_STEP = 4'd1;
  localparam int unsigned       DEF_DUR  = 1;

  function automatic int unsigned entry_w(input int unsigned dur_w);
    return MODE_W + STEP_W + dur_w;
  endfunction

endpackage

// File: rtl/wave_phase_gen.sv
// 8-bit phase accumulator; a zero step advances by one, wrap_c flags the add carry.
module wave_phase_gen
  import wave_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [PH_W-1:0]   phase,
  output logic              wrap_c
);

  logic [STEP_W-1:0] eff_step;
  logic [PH_W:0]     sum;

  always_comb begin
    eff_step = (step == '0) ? STEP_W'(1) : step;
    sum      = {1'b0, phase} + (PH_W+1)'(eff_step);
    wrap_c   = en & sum[PH_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= sum[PH_W-1:0];
    end
  end

endmodule

// File: rtl/wave_seq_ctrl.sv
// Programmable waveform sequencer: plays a table of {mode, step, dur} segments,
// optionally looping, and decodes the phase accumulator into an 8-bit sample.
module wave_seq_ctrl
  import wave_seq_pkg::*;
#(
  parameter  int unsigned NSEG  = 4,
  parameter  int unsigned DUR_W = 8,
  localparam int unsigned SEG_W = $clog2(NSEG),
  localparam int unsigned ENT_W = entry_w(DUR_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SEG_W-1:0] wr_addr,
  input  logic [ENT_W-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [OP_W-1:0]  op,
  output logic             busy,
  output logic             done,
  output logic [SEG_W-1:0] seg
);

  localparam int unsigned STEP_LSB = DUR_LSB + DUR_W;
  localparam int unsigned MODE_LSB = STEP_LSB + STEP_W;
  localparam logic [ENT_W-1:0] DEF_ENTRY = {DEF_MODE, DEF_STEP, DUR_W'(DEF_DUR)};

  logic [ENT_W-1:0]  tbl [NSEG];
  logic [ENT_W-1:0]  cur;
  logic [MODE_W-1:0] cur_mode;
  logic [STEP_W-1:0] cur_step;
  logic [DUR_W-1:0]  cur_dur;

  state_e            state, state_nxt;
  logic [SEG_W-1:0]  seg_nxt;
  logic [MODE_W-1:0] work_mode, mode_nxt;
  logic [STEP_W-1:0] work_step, step_nxt;
  logic [DUR_W-1:0]  work_dur, dur_nxt;
  logic [DUR_W-1:0]  wrap_cnt, wrap_nxt;
  logic              seg_end;

  logic [PH_W-1:0]   phase;
  logic              wrap_c;
  logic              run;

  // Program table; the entry is only read during LOAD, so live rewrites apply next pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NSEG; i++) tbl[i] <= DEF_ENTRY;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    cur      = tbl[seg];
    cur_mode = cur[MODE_LSB +: MODE_W];
    cur_step = cur[STEP_LSB +: STEP_W];
    cur_dur  = cur[DUR_LSB +: DUR_W];
  end

  assign run = (state == ST_RUN);

  wave_phase_gen u_phase (
    .clk    (clk),
    .rst    (rst),
    .clr    (!run),
    .en     (run),
    .step   (work_step),
    .phase  (phase),
    .wrap_c (wrap_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      seg       <= '0;
      work_mode <= '0;
      work_step <= '0;
      work_dur  <= '0;
      wrap_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      seg       <= seg_nxt;
      work_mode <= mode_nxt;
      work_step <= step_nxt;
      work_dur  <= dur_nxt;
      wrap_cnt  <= wrap_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    seg_nxt   = seg;
    mode_nxt  = work_mode;
    step_nxt  = work_step;
    dur_nxt   = work_dur;
    wrap_nxt  = wrap_cnt;
    seg_end   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_LOAD;
          seg_nxt   = '0;
        end
      end
      ST_LOAD: begin
        mode_nxt = cur_mode;
        step_nxt = cur_step;
        dur_nxt  = cur_dur;
        wrap_nxt = '0;
        if (cur_dur == '0) seg_end = 1'b1;
        else               state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (wrap_c) begin
          wrap_nxt = wrap_cnt + 1'b1;
          if ((DUR_W+1)'(wrap_cnt) + (DUR_W+1)'(1) == (DUR_W+1)'(work_dur)) seg_end = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (seg_end) begin
      if (seg != SEG_W'(NSEG - 1)) begin
        seg_nxt   = seg + 1'b1;
        state_nxt = ST_LOAD;
      end else if (loop) begin
        seg_nxt   = '0;
        state_nxt = ST_LOAD;
      end else begin
        state_nxt = ST_DONE;
      end
    end

    // Abort wins over segment completion; seg keeps its current value.
    if (stop && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      seg_nxt   = seg;
    end
  end

  always_comb begin
    op = '0;
    if (run) begin
      case (work_mode)
        MODE_SQ_HI:  op = phase[7] ? 8'hFF : 8'h00;
        MODE_SQ_MID: op = phase[6] ? 8'hFF : 8'h00;
        MODE_RAMP:   op = phase;
        default:     op = '0;
      endcase
    end
  end

endmodule
